// File: rtl/apb_mem_ctrl_if.sv
// APB4 completer-side bundle between the interconnect
// and the SRAM front-end.
interface apb_mem_ctrl_if #(
  parameter int PADDR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32
);
  logic                    psel_i;
  logic                    penable_i;
  logic [PADDR_WIDTH-1:0]  paddr_i;
  logic                    pwrite_i;
  logic [DATA_WIDTH-1:0]   pwdata_i;
  logic [DATA_WIDTH/8-1:0] pstrb_i;
  logic                    pready_o;
  logic [DATA_WIDTH-1:0]   prdata_o;
  logic                    pslverr_o;

  modport master (
    output psel_i, penable_i, paddr_i,
    output pwrite_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, paddr_i,
    input  pwrite_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o
  );
endinterface

// File: rtl/apb_mem_ctrl.sv
// APB4 slave front-end for a sync-write/async-read SRAM:
// window decode, programmable wait states, 1-cycle strobe.
module apb_mem_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int PADDR_WIDTH = 32,
  parameter logic [PADDR_WIDTH-1:0] BASE_ADDR = 'h1000,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  apb_mem_ctrl_if.slave           apb,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [PADDR_WIDTH-1:0] WIN =
    PADDR_WIDTH'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic                    r_hit;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [SW-1:0]           r_strb;
  logic [3:0]              r_cnt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_slverr;
  logic                    w_setup;
  logic                    w_issue;
  logic                    w_hit;
  logic                    w_resp;
  logic [PADDR_WIDTH-1:0]  w_off;

  // Unsigned offset compare; wraps harmlessly below base.
  assign w_off = apb.paddr_i - BASE_ADDR;
  assign w_hit = (apb.paddr_i >= BASE_ADDR) &&
                 (w_off < WIN);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_setup = 1'b0;
    w_issue = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (apb.psel_i && !apb.penable_i) begin
          w_setup = 1'b1;
          w_next  = WAIT;
        end
      end
      WAIT: begin
        if (!apb.psel_i) begin
          w_next = IDLE;
        end else if (r_cnt == 4'd0) begin
          w_issue = 1'b1;
          w_next  = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_hit    <= 1'b0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
    end else begin
      if (w_setup) begin
        r_addr  <= apb.paddr_i[ADDR_WIDTH-1:0];
        r_write <= apb.pwrite_i;
        r_hit   <= w_hit;
        r_wdata <= apb.pwdata_i;
        r_strb  <= apb.pstrb_i;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == WAIT && apb.psel_i &&
                   r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_issue) begin
        r_rdata  <= (!r_write && r_hit) ?
                    mem_rdata_i : '0;
        r_slverr <= !r_hit;
      end
    end
  end

  assign w_resp        = (r_state == RESP);
  assign apb.pready_o  = w_resp;
  assign apb.prdata_o  = w_resp ? r_rdata : '0;
  assign apb.pslverr_o = w_resp && r_slverr;

  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wstrb_o = r_write ? r_strb : '0;
  assign mem_we_o    = w_issue && r_write &&
                       r_hit && apb.penable_i;

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// Directed bench: three controllers (1, 0 and 3 wait
// states) each backed by a small behavioural SRAM.
module tb_apb_mem_ctrl;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  int          sel = 0;
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  logic [2:0]  we_v;
  logic [2:0]  rdy_v;
  logic [2:0]  err_v;
  logic [31:0] prd_v [3];
  logic [3:0]  addr_v [3];
  logic [3:0]  strb_v [3];
  logic [31:0] wd_v [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int W = (k == 0) ? 1 : (k == 1) ? 0 : 3;
    apb_mem_ctrl_if #(
      .PADDR_WIDTH(32),
      .DATA_WIDTH(32)
    ) bus ();
    logic [3:0]  maddr;
    logic        mwe;
    logic [31:0] mwd;
    logic [3:0]  mws;
    logic [31:0] mrd;
    logic [31:0] mem [4];

    assign bus.psel_i    = psel && (sel == k);
    assign bus.penable_i = penable;
    assign bus.paddr_i   = paddr;
    assign bus.pwrite_i  = pwrite;
    assign bus.pwdata_i  = pwdata;
    assign bus.pstrb_i   = pstrb;

    apb_mem_ctrl #(
      .ADDR_WIDTH(4),
      .DATA_WIDTH(32),
      .PADDR_WIDTH(32),
      .BASE_ADDR(32'h0000_1000),
      .WAIT_CYCLES(W)
    ) u_dut (
      .clk_i(clk),
      .arst_i(arst),
      .apb(bus),
      .mem_addr_o(maddr),
      .mem_we_o(mwe),
      .mem_wdata_o(mwd),
      .mem_wstrb_o(mws),
      .mem_rdata_i(mrd)
    );

    always @(posedge clk)
      if (mwe)
        for (int b = 0; b < 4; b++)
          if (mws[b])
            mem[maddr[3:2]][b*8 +: 8] <= mwd[b*8 +: 8];

    assign mrd       = mem[maddr[3:2]];
    assign we_v[k]   = mwe;
    assign rdy_v[k]  = bus.pready_o;
    assign err_v[k]  = bus.pslverr_o;
    assign prd_v[k]  = bus.prdata_o;
    assign addr_v[k] = maddr;
    assign strb_v[k] = mws;
    assign wd_v[k]   = mwd;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic xfer(input bit wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      output logic [31:0] rd,
                      output logic err,
                      output int lat,
                      output int wes,
                      output int rcyc);
    bit got;
    rd = '0; err = 1'b0; wes = 0; rcyc = 0; got = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    lat = 1;
    @(negedge clk);
    wes += int'(we_v[sel]);
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      lat++;
      @(negedge clk);
      wes += int'(we_v[sel]);
      if (rdy_v[sel]) begin
        got  = 1;
        rd   = prd_v[sel];
        err  = err_v[sel];
        rcyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("pready_timeout", 32'(got), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, wes, c1, c2;

  initial begin
    #3;
    chk("rst_pready", 32'(rdy_v[0]), 32'd0);
    chk("rst_we",     32'(we_v[0]),  32'd0);
    chk("rst_addr",   32'(addr_v[0]), 32'd0);
    chk("rst_wdata",  wd_v[0],       32'd0);
    chk("rst_prdata", prd_v[0],      32'd0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;

    // Unit 0: one wait state
    sel = 0;
    xfer(1, 32'h1004, 32'hDEADBEEF, 4'hF, rd, er, lat, wes, c1);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_we_pulses", 32'(wes), 32'd1);
    chk("wr_slverr", 32'(er), 32'd0);
    xfer(0, 32'h1004, 32'h0, 4'h0, rd, er, lat, wes, c1);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_we_pulses", 32'(wes), 32'd0);
    chk("rd_latency", 32'(lat), 32'd4);
    xfer(0, 32'h1006, 32'h0, 4'h0, rd, er, lat, wes, c1);
    chk("rd_subword", rd, 32'hDEADBEEF);

    xfer(1, 32'h1008, 32'h11223344, 4'hF, rd, er, lat, wes, c1);
    xfer(1, 32'h1008, 32'hAABBCCDD, 4'h5, rd, er, lat, wes, c1);
    chk("pwr_we_pulses", 32'(wes), 32'd1);
    xfer(0, 32'h1008, 32'h0, 4'h0, rd, er, lat, wes, c1);
    chk("pwr_readback", rd, 32'h11BB33DD);

    xfer(1, 32'h1010, 32'h12345678, 4'hF, rd, er, lat, wes, c1);
    chk("oor_wr_slverr", 32'(er), 32'd1);
    chk("oor_wr_we", 32'(wes), 32'd0);
    xfer(0, 32'h0FFC, 32'h0, 4'h0, rd, er, lat, wes, c1);
    chk("oor_rd_slverr", 32'(er), 32'd1);
    chk("oor_rd_data", rd, 32'd0);

    xfer(1, 32'h1004, 32'h0, 4'h0, rd, er, lat, wes, c1);
    chk("zstrb_we_pulses", 32'(wes), 32'd1);
    chk("zstrb_slverr", 32'(er), 32'd0);
    xfer(0, 32'h1004, 32'h0, 4'h0, rd, er, lat, wes, c1);
    chk("zstrb_unchanged", rd, 32'hDEADBEEF);
    idle();

    // Unit 1: zero wait states, back-to-back
    sel = 1;
    xfer(1, 32'h1000, 32'hA5A5A5A5, 4'hF, rd, er, lat, wes, c1);
    chk("b2b_w1_lat", 32'(lat), 32'd3);
    chk("b2b_w1_we", 32'(wes), 32'd1);
    xfer(1, 32'h100C, 32'h5A5A5A5A, 4'hF, rd, er, lat, wes, c2);
    chk("b2b_w2_lat", 32'(lat), 32'd3);
    chk("b2b_w2_we", 32'(wes), 32'd1);
    chk("b2b_spacing", 32'(c2 - c1), 32'd3);
    xfer(0, 32'h1000, 32'h0, 4'h0, rd, er, lat, wes, c1);
    chk("b2b_rd1", rd, 32'hA5A5A5A5);
    xfer(0, 32'h100C, 32'h0, 4'h0, rd, er, lat, wes, c1);
    chk("b2b_rd2", rd, 32'h5A5A5A5A);
    idle();

    // Unit 2: three wait states, aborted transfer
    sel = 2;
    xfer(1, 32'h1004, 32'h01020304, 4'hF, rd, er, lat, wes, c1);
    chk("w3_latency", 32'(lat), 32'd6);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h1004; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    wes = 0; lat = 0;
    repeat (6) begin
      @(negedge clk);
      wes += int'(we_v[2]);
      lat += int'(rdy_v[2]);
    end
    chk("abort_we", 32'(wes), 32'd0);
    chk("abort_pready", 32'(lat), 32'd0);
    xfer(0, 32'h1004, 32'h0, 4'h0, rd, er, lat, wes, c1);
    chk("abort_next_rd", rd, 32'h01020304);
    chk("abort_next_err", 32'(er), 32'd0);
    idle();

    // Unit 0: reset asserted mid-write
    sel = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h1004; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("mid_addr", 32'(addr_v[0]), 32'h4);
    arst = 1'b1;
    #1;
    chk("arst_pready", 32'(rdy_v[0]), 32'd0);
    chk("arst_we", 32'(we_v[0]), 32'd0);
    chk("arst_addr", 32'(addr_v[0]), 32'd0);
    chk("arst_strb", 32'(strb_v[0]), 32'd0);
    chk("arst_wdata", wd_v[0], 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    arst = 1'b0;
    xfer(0, 32'h1004, 32'h0, 4'h0, rd, er, lat, wes, c1);
    chk("arst_old_data", rd, 32'hDEADBEEF);
    chk("arst_rd_latency", 32'(lat), 32'd4);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/apb_mem_ctrl.md
Name: apb_mem_ctrl

Overview:
- APB4 slave front-end that sits directly upstream of the synchronous-write/asynchronous-read SRAM macro in the SoC memory subsystem.
- Decodes an address window, inserts a programmable number of wait states, and issues a single-cycle write strobe or read sample to the memory port.
- Returns pready/prdata/pslverr to the bus interconnect.

Parameters:
- ADDR_WIDTH, 4, memory byte-address width; window size = 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 32, bus and memory data width; multiple of 8.
- PADDR_WIDTH, 32, APB address width.
- BASE_ADDR, 32'h0000_1000, window base; aligned to 2**ADDR_WIDTH.
- WAIT_CYCLES, 1, extra wait cycles before memory access; 0..15.

Ports:
- clk_i  input  1  clock, rising edge
- arst_i  input  1  asynchronous active-high reset
- psel_i  input  1  APB select
- penable_i  input  1  APB enable (access phase)
- paddr_i  input  PADDR_WIDTH  APB byte address
- pwrite_i  input  1  1=write, 0=read
- pwdata_i  input  DATA_WIDTH  write data
- pstrb_i  input  DATA_WIDTH/8  byte strobes
- pready_o  output  1  transfer complete
- prdata_o  output  DATA_WIDTH  read data
- pslverr_o  output  1  error response
- mem_addr_o  output  ADDR_WIDTH  memory byte address
- mem_we_o  output  1  memory write enable
- mem_wdata_o  output  DATA_WIDTH  memory write data
- mem_wstrb_o  output  DATA_WIDTH/8  memory byte strobes
- mem_rdata_i  input  DATA_WIDTH  memory read data (combinational from mem_addr_o)

Behaviour:
- One clock domain, clk_i. arst_i is asynchronous and active-high.
- Reset state:
  - FSM = IDLE; all outputs 0.
  - Latched address, data and strobe registers = 0.
  - Wait counter = 0.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - On psel_i=1 and penable_i=0 (setup phase), at the clock edge:
    - latch paddr_i, pwrite_i, pwdata_i and pstrb_i;
    - compute hit = (paddr_i >= BASE_ADDR) && (paddr_i - BASE_ADDR < 2**ADDR_WIDTH), using an unsigned PADDR_WIDTH compare;
    - load cnt = WAIT_CYCLES;
    - go to WAIT.
  - psel_i=1 with penable_i=1 while in IDLE is a protocol error. It is ignored and the FSM stays in IDLE.
- WAIT:
  - pready_o = 0.
  - If psel_i=0 (aborted transfer), go to IDLE. No memory write and no response.
  - Else if cnt != 0, cnt <= cnt-1.
  - Else (cnt == 0) this is the issue cycle:
    - mem_we_o = latched write && hit && psel_i && penable_i, asserted combinationally for exactly this cycle;
    - prdata register <= (!write && hit) ? mem_rdata_i : 0;
    - pslverr register <= !hit;
    - go to RESP.
- RESP:
  - pready_o = 1 for exactly one cycle, with prdata_o and pslverr_o valid in that same cycle.
  - Next state is IDLE unconditionally.
  - A back-to-back setup phase in the following cycle is accepted from IDLE.
- Outside RESP, pready_o = 0, prdata_o = 0 and pslverr_o = 0.
- Latency:
  - Access phase is WAIT_CYCLES+2 cycles.
  - Total transfer (setup + access) is WAIT_CYCLES+3 cycles.
  - Memory write lands at the clock edge ending the issue cycle.
- Memory-side drive:
  - mem_addr_o = latched paddr[ADDR_WIDTH-1:0], held stable from the first WAIT cycle through RESP.
  - mem_wdata_o = latched pwdata.
  - mem_wstrb_o = latched pstrb on writes, 0 on reads.
- Write corner cases:
  - Write with pstrb_i=0: mem_we_o still pulses with strobe 0; memory content is unchanged; pslverr_o=0.
  - Out-of-range access: no mem_we_o pulse, prdata_o=0, pslverr_o=1.
- Address alignment: sub-word address bits are passed through unchanged; the memory ignores them (word-addressed rows).
- Reset mid-transfer: FSM returns to IDLE immediately. The write is not issued if reset is asserted before the issue cycle's edge, and no pready_o is produced.

Test Plan:
- WAIT_CYCLES=1, write 0x1004 with data 0xDEADBEEF and pstrb 0xF, then read 0x1004.
  - Write: mem_we_o high exactly 1 cycle, pready_o on the 4th cycle after setup starts, pslverr_o=0.
  - Read: prdata_o=0xDEADBEEF.
- Partial write to 0x1008: first write 0x11223344 with pstrb 0xF, then write 0xAABBCCDD with pstrb 0x5.
  - Read back 0x11BB33DD.
- Out-of-range:
  - Write to 0x1010: pslverr_o=1, no mem_we_o pulse.
  - Read from 0x0FFC: pslverr_o=1, prdata_o=0.
- WAIT_CYCLES=0 back-to-back writes with no idle cycle: two write pulses, and both pready_o pulses arrive 3 cycles apart.
- Abort: drop psel_i during WAIT with WAIT_CYCLES=3.
  - No mem_we_o pulse and no pready_o; the next transfer completes normally.
- Assert arst_i during WAIT of a write:
  - All outputs go to 0 asynchronously and the target word is unchanged.
  - After release, the FSM is in IDLE and the next read returns the old data.
